// File: rtl/line_scaler_pkg.sv
// Shared constants, state encoding and index saturation for the line scaler.
package line_scaler_pkg;

  localparam int LINE_WIDTH    = 640;
  localparam int LINEBUF_DEPTH = 768;
  localparam int HSCALE_UNITY  = 128;
  localparam int PIPE_DEPTH    = 2;
  localparam int ACC_W         = 17;
  localparam int FRAC_W        = 7;
  localparam int IDX_W         = ACC_W - FRAC_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  function automatic logic [IDX_W-1:0] sat_idx(input logic [IDX_W-1:0] raw);
    if (raw > IDX_W'(LINEBUF_DEPTH - 1)) return IDX_W'(LINEBUF_DEPTH - 1);
    return raw;
  endfunction

endpackage

// File: rtl/line_scaler_accum.sv
// 10.7 source-position accumulator; sticks at full scale instead of wrapping,
// and its integer part is clamped to the line buffer depth.
module line_scaler_accum
  import line_scaler_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             adv_i,
  input  logic [7:0]       step_i,
  output logic [IDX_W-1:0] idx_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, step_i};

  always_comb begin
    acc_d = acc_q;
    if (clear_i)    acc_d = '0;
    else if (adv_i) acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign idx_o = sat_idx(acc_q[ACC_W-1:FRAC_W]);

endmodule

// File: rtl/line_scaler.sv
// Horizontal line scaler: FSM, line buffer addressing and 2-stage output pipe.
// Define LINE_SCALER_BORDER_EN to enable the [hstart, hstop) window with border fill.
module line_scaler
  import line_scaler_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_start,
  input  logic [7:0] hscale,
  input  logic [9:0] hstart,
  input  logic [9:0] hstop,
  input  logic [7:0] border_color,
  output logic [9:0] composer_rd_idx,
  input  logic [7:0] composer_rd_data,
  output logic [7:0] pixel_out,
  output logic       pixel_valid,
  output logic       line_done
);

  state_e          state_q, state_d;
  logic [9:0]      x_q, x_d;
  logic [1:0]      fl_cnt_q, fl_cnt_d;
  logic [7:0]      hscale_q;
  logic [PIPE_DEPTH-1:0] vld_pipe_q, last_pipe_q;
  logic [7:0]      pix_q;
  logic [9:0]      acc_idx;
  logic            issue, last_issue, in_win;

  assign issue      = (state_q == ST_ACTIVE);
  assign last_issue = issue && (x_q == 10'(LINE_WIDTH - 1));

`ifdef LINE_SCALER_BORDER_EN
  logic [9:0] hstart_q, hstop_q;
  logic       bord_q;

  assign in_win = (x_q >= hstart_q) && (x_q < hstop_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hstart_q <= '0;
      hstop_q  <= '0;
      bord_q   <= 1'b0;
    end else begin
      if (line_start) begin
        hstart_q <= hstart;
        hstop_q  <= hstop;
      end
      bord_q <= !in_win;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{hstart, hstop, border_color};
  assign in_win     = 1'b1;
`endif

  line_scaler_accum u_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (line_start),
    .adv_i   (issue && in_win),
    .step_i  (hscale_q),
    .idx_o   (acc_idx)
  );

  assign composer_rd_idx = issue ? acc_idx : '0;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    fl_cnt_d = fl_cnt_q;
    case (state_q)
      ST_ACTIVE: begin
        x_d = x_q + 10'd1;
        if (last_issue) begin
          state_d  = ST_FLUSH;
          fl_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        fl_cnt_d = fl_cnt_q + 2'd1;
        if (fl_cnt_q == 2'(PIPE_DEPTH - 1)) state_d = ST_IDLE;
      end
      default: ;
    endcase
    // A new line_start restarts from any state, aborting whatever is in flight.
    if (line_start) begin
      state_d = ST_ACTIVE;
      x_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      fl_cnt_q <= '0;
      hscale_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      fl_cnt_q <= fl_cnt_d;
      if (line_start) hscale_q <= hscale;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      pix_q       <= '0;
    end else begin
      if (line_start) begin
        vld_pipe_q  <= '0;
        last_pipe_q <= '0;
      end else begin
        vld_pipe_q  <= {vld_pipe_q[PIPE_DEPTH-2:0], issue};
        last_pipe_q <= {last_pipe_q[PIPE_DEPTH-2:0], last_issue};
      end
`ifdef LINE_SCALER_BORDER_EN
      if (vld_pipe_q[0]) pix_q <= bord_q ? border_color : composer_rd_data;
`else
      if (vld_pipe_q[0]) pix_q <= composer_rd_data;
`endif
    end
  end

  assign pixel_out   = pix_q;
  assign pixel_valid = vld_pipe_q[PIPE_DEPTH-1];
  assign line_done   = last_pipe_q[PIPE_DEPTH-1];

endmodule

// File: tb/tb_line_scaler.sv
// Self-checking bench for line_scaler: randomized lines against a per-pixel reference model.
module tb_line_scaler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line_start = 1'b0;
  logic [7:0] hscale = 8'd0;
  logic [9:0] hstart = 10'd0, hstop = 10'd0;
  logic [7:0] border_color = 8'd0;
  logic [9:0] composer_rd_idx;
  logic [7:0] composer_rd_data;
  logic [7:0] pixel_out;
  logic       pixel_valid, line_done;

  logic [7:0] mem [768];
  int n_vec = 0, n_err = 0, cur_k = 0;

  always #5 clk = ~clk;

  always @(posedge clk) composer_rd_data <= mem[composer_rd_idx];

  line_scaler dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .line_start       (line_start),
    .hscale           (hscale),
    .hstart           (hstart),
    .hstop            (hstop),
    .border_color     (border_color),
    .composer_rd_idx  (composer_rd_idx),
    .composer_rd_data (composer_rd_data),
    .pixel_out        (pixel_out),
    .pixel_valid      (pixel_valid),
    .line_done        (line_done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s k=%0d: got %0d expected %0d", tag, cur_k, obs, exp);
    end
  endtask

  // Source index of output pixel x, or -1 for a border pixel.
  function automatic int exp_idx(int x, int h, int hs, int he);
    int s;
`ifdef LINE_SCALER_BORDER_EN
    if (x < hs || x >= he) return -1;
    s = ((x - hs) * h) / 128;
`else
    s = (x * h) / 128;
`endif
    return (s > 767) ? 767 : s;
  endfunction

  function automatic int exp_pix(int x, int h, int hs, int he, int bc);
    int i;
    i = exp_idx(x, h, hs, he);
    return (i < 0) ? bc : int'(mem[i]);
  endfunction

  // Pulses line_start at the current negedge, then checks each following
  // negedge k; returns at negedge stop_at (or after the line drains).
  task automatic run_line(input int h, input int hs, input int he, input int bc, input int stop_at);
    int e;
    hscale = 8'(h); hstart = 10'(hs); hstop = 10'(he); border_color = 8'(bc);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    for (int k = 0; k < 646; k++) begin
      if (k == stop_at) return;
      cur_k = k;
      if (k < 640) begin
        e = exp_idx(k, h, hs, he);
        if (e >= 0) chk("rd_idx", int'(composer_rd_idx), e);
      end else begin
        chk("rd_idx_idle", int'(composer_rd_idx), 0);
      end
      chk("valid", int'(pixel_valid), int'(k >= 2 && k < 642));
      chk("done", int'(line_done), int'(k == 641));
      if (k >= 2 && k < 642) chk("pixel", int'(pixel_out), exp_pix(k - 2, h, hs, he, bc));
      @(negedge clk);
    end
  endtask

  task automatic check_quiet(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      cur_k = -1;
      chk("quiet_valid", int'(pixel_valid), 0);
      chk("quiet_idx", int'(composer_rd_idx), 0);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_pix", int'(pixel_out), 0);
    chk("rst_valid", int'(pixel_valid), 0);
    chk("rst_done", int'(line_done), 0);
    chk("rst_idx", int'(composer_rd_idx), 0);
  endtask

  initial begin
    for (int i = 0; i < 768; i++) mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet(5);

    run_line(128, 0, 640, 0, -1);
    run_line(64, 0, 640, 0, -1);
    run_line(255, 0, 640, 0, -1);
    for (int i = 0; i < 768; i++) mem[i] = 8'($urandom);
    run_line(0, 0, 640, 0, -1);
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 768; i++) mem[i] = 8'($urandom);
      run_line(int'($urandom_range(1, 255)), int'($urandom_range(0, 300)),
               int'($urandom_range(200, 640)), int'($urandom_range(0, 255)), -1);
    end
`ifdef LINE_SCALER_BORDER_EN
    run_line(128, 100, 200, 8'h0F, -1);
    run_line(96, 300, 200, 8'hA5, -1);
`endif

    // Abort mid-line, then a fresh full line must follow.
    run_line(128, 0, 640, 0, 300);
    run_line(int'($urandom_range(1, 255)), 50, 600, 8'h3C, -1);

    // Reset mid-line: outputs clear at once and stay quiet until line_start.
    run_line(128, 0, 640, 0, 300);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet(20);
    run_line(64, 10, 630, 8'h11, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/line_scaler.md
LINE_SCALER -- requirements
Module: line_scaler

Interface
REQ-001 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port line_start, input, 1: one-cycle pulse that starts output of one 640-pixel active line.
REQ-004 SHALL have port hscale, input, 8: source step per output pixel in 1/128 units (128 = 1:1, 64 = 2x zoom); sampled at line_start.
REQ-005 SHALL have port hstart, input, 10, and port hstop, input, 10: active window in output pixels [hstart, hstop); sampled at line_start.
REQ-006 SHALL have port border_color, input, 8: palette index output outside the window.
REQ-007 SHALL have port composer_rd_idx, output, 10: line buffer read index.
REQ-008 SHALL have port composer_rd_data, input, 8: line buffer data, valid one cycle after composer_rd_idx.
REQ-009 SHALL have port pixel_out, output, 8, and port pixel_valid, output, 1: scaled pixel stream, one pixel per clock while valid.
REQ-010 SHALL have port line_done, output, 1: one-cycle pulse coincident with the final pixel_valid of a line.

Function
REQ-011 SHALL implement states IDLE, ACTIVE and FLUSH; reset enters IDLE.
REQ-012 In IDLE, line_start SHALL load x=0, accumulator=0 and the sampled config, and go to ACTIVE next cycle.
REQ-013 In ACTIVE, each cycle SHALL issue composer_rd_idx = accumulator[16:7], then x += 1 and accumulator += hscale.
REQ-014 Accumulator SHALL be 17 bits (10.7 fixed point); composer_rd_idx SHALL saturate at 767 when accumulator[16:7] > 767.
REQ-015 After issuing x=639, SHALL go to FLUSH; FLUSH SHALL last exactly the pipeline depth, then return to IDLE.
REQ-016 pixel_out/pixel_valid SHALL appear exactly 2 cycles after the corresponding composer_rd_idx (1 RAM + 1 output register).
REQ-017 pixel_valid SHALL assert for exactly 640 consecutive cycles per line; line_done SHALL pulse with pixel 639.
REQ-018 line_start during ACTIVE or FLUSH SHALL abort the current line (in-flight pixels dropped, pixel_valid low next cycle) and restart from x=0.
REQ-019 hscale=0 SHALL repeat source pixel 0 for the whole line; hscale=255 SHALL advance ~2 per pixel, with clamping per REQ-014.
REQ-020 hstart >= hstop SHALL yield an empty window (all border when REQ-025 is enabled).
REQ-021 composer_rd_idx SHALL be held at 0 in IDLE.

Reset
REQ-022 Reset SHALL immediately clear pixel_out=0, pixel_valid=0, line_done=0, composer_rd_idx=0, x=0, accumulator=0 and state=IDLE, including mid-line.
REQ-023 After reset release, no pixel_valid SHALL occur before a line_start.

Configuration
REQ-024 Macro LINE_SCALER_BORDER_EN SHALL select border support.
REQ-025 With LINE_SCALER_BORDER_EN defined, output pixels with x < hstart or x >= hstop SHALL be border_color, and the accumulator SHALL advance only for x inside the window, starting from 0 at x=hstart.
REQ-026 Without it, hstart, hstop and border_color SHALL be ignored, and every pixel SHALL come from the line buffer with the accumulator advancing every cycle.

Structure
REQ-027 A shared constants include SHALL hold LINE_WIDTH=640, LINEBUF_DEPTH=768, HSCALE_UNITY=128, the PIPE_DEPTH=2 value and the state encodings.
REQ-028 The 10.7 accumulator with saturation SHALL be a sub-module named line_scaler_accum; the FSM and output pipeline SHALL stay in line_scaler.

Verification
REQ-029 Reset, then pulse line_start with hscale=128 and a buffer holding idx[7:0] -> pixel_out sequence 0,1,...,255,0,...; first valid pixel 3 cycles after the pulse; 640 valid pixels; line_done at the last one.
REQ-030 hscale=64 -> each source pixel output twice, with final composer_rd_idx=319.
REQ-031 hscale=255 -> composer_rd_idx clamps at 767 and holds for the remainder of the line.
REQ-032 With BORDER_EN, hstart=100, hstop=200, border_color=0x0F -> pixels 0-99 and 200-639 are 0x0F; pixel 100 equals buffer[0].
REQ-033 line_start at pixel 300 -> pixel_valid drops for the restart gap; a fresh 640-pixel line follows.
REQ-034 rst_n asserted at pixel 300 -> all outputs are 0 immediately; nothing is output until the next line_start.
